// File: rtl/time_cascade_if.sv
// Control, digit-feedback and strobe bundle between the timekeeper top level and the cascade controller.
// master drives controls and digit values; slave (the controller) drives strobes and mode.
interface time_cascade_if;
  logic       start;
  logic       stop;
  logic       set_en;
  logic       inc_sec;
  logic       inc_min;
  logic       clr;
  logic       fast;
  logic [3:0] q_s0;
  logic [3:0] q_s1;
  logic [3:0] q_m0;
  logic [3:0] q_m1;
  logic [3:0] ce;
  logic [3:0] ld;
  logic       tick;
  logic       rollover;
  logic [1:0] mode;

  modport master (
    output start, stop, set_en, inc_sec, inc_min, clr, fast,
    output q_s0, q_s1, q_m0, q_m1,
    input  ce, ld, tick, rollover, mode
  );

  modport slave (
    input  start, stop, set_en, inc_sec, inc_min, clr, fast,
    input  q_s0, q_s1, q_m0, q_m1,
    output ce, ld, tick, rollover, mode
  );
endinterface

// File: rtl/time_cascade_ctrl.sv
// MM:SS timekeeper controller: 1 Hz prescaler, run/stop/set FSM and BCD carry cascade
// driving the ce/ld strobes of the four digit counters (load data is zero).
module time_cascade_ctrl #(
  parameter int unsigned DIV      = 12000000,
  parameter int unsigned FAST_DIV = 4,
  parameter int unsigned PW       = 24
) (
  input  logic          clk,
  input  logic          rst,
  time_cascade_if.slave bus
);

  typedef enum logic [1:0] {
    ST_STOP = 2'b00,
    ST_RUN  = 2'b01,
    ST_SET  = 2'b10
  } state_e;

  localparam logic [PW-1:0] DIV_M1      = PW'(DIV - 1);
  localparam logic [PW-1:0] FAST_DIV_M1 = PW'(FAST_DIV - 1);
  localparam logic [3:0]    DIGIT_NINE  = 4'd9;
  localparam logic [3:0]    DIGIT_FIVE  = 4'd5;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          inc_sec_q, inc_min_q;
  logic [3:0]    ce_q, ce_d;
  logic [3:0]    ld_q, ld_d;
  logic          tick_q, tick_d;
  logic          roll_q, roll_d;

  logic          run_c;
  logic          adv_s_c, adv_m_c;
  logic          c0_c, c1_c, c2_c, c3_c;
  logic [PW-1:0] wrap_at_c;

  // State, prescaler, button history and registered strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_STOP;
      presc_q   <= '0;
      inc_sec_q <= 1'b0;
      inc_min_q <= 1'b0;
      ce_q      <= '0;
      ld_q      <= '0;
      tick_q    <= 1'b0;
      roll_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      inc_sec_q <= bus.inc_sec;
      inc_min_q <= bus.inc_min;
      ce_q      <= ce_d;
      ld_q      <= ld_d;
      tick_q    <= tick_d;
      roll_q    <= roll_d;
    end
  end

  // Next state, advance sources and carry cascade
  always_comb begin
    state_d   = state_q;
    presc_d   = '0;
    adv_s_c   = 1'b0;
    adv_m_c   = 1'b0;
    run_c     = (state_q == ST_RUN);
    wrap_at_c = bus.fast ? FAST_DIV_M1 : DIV_M1;

    if (bus.set_en) begin
      state_d = ST_SET;
    end else begin
      case (state_q)
        ST_SET:  state_d = ST_STOP;
        ST_RUN:  if (bus.stop)  state_d = ST_STOP;
        ST_STOP: if (bus.start) state_d = ST_RUN;
        default: state_d = ST_STOP;
      endcase
    end

    // >= so a mid-count switch to the shorter divisor wraps on the next cycle
    if (run_c) begin
      if (presc_q >= wrap_at_c) begin
        presc_d = '0;
        adv_s_c = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else if (state_q == ST_SET) begin
      adv_s_c = bus.inc_sec & ~inc_sec_q;
      adv_m_c = bus.inc_min & ~inc_min_q;
    end

    c0_c = adv_s_c;
    c1_c = c0_c & (bus.q_s0 == DIGIT_NINE);
    c2_c = run_c ? (c1_c & (bus.q_s1 == DIGIT_FIVE)) : adv_m_c;
    c3_c = c2_c & (bus.q_m0 == DIGIT_NINE);

    ce_d   = {c3_c, c2_c, c1_c, c0_c};
    ld_d   = {c3_c & (bus.q_m1 == DIGIT_FIVE),
              c2_c & (bus.q_m0 == DIGIT_NINE),
              c1_c & (bus.q_s1 == DIGIT_FIVE),
              c0_c & (bus.q_s0 == DIGIT_NINE)};
    tick_d = run_c & adv_s_c;
    roll_d = run_c & c3_c & (bus.q_m1 == DIGIT_FIVE);

    // Clear loads zero into every digit and wins over any same-cycle increment
    if (bus.clr && !run_c) begin
      ce_d = 4'hF;
      ld_d = 4'hF;
    end
  end

  assign bus.ce       = ce_q;
  assign bus.ld       = ld_q;
  assign bus.tick     = tick_q;
  assign bus.rollover = roll_q;
  assign bus.mode     = state_q;

endmodule

// File: tb/tb_time_cascade_ctrl.sv
// Directed bench for time_cascade_ctrl: DIV=4, FAST_DIV=2; inputs driven and outputs
// sampled 1 time unit after each rising clock edge.
module tb_time_cascade_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  time_cascade_if bus ();

  time_cascade_ctrl #(
    .DIV      (4),
    .FAST_DIV (2),
    .PW       (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_q(input logic [3:0] m1, input logic [3:0] m0,
                       input logic [3:0] s1, input logic [3:0] s0);
    bus.q_m1 = m1;
    bus.q_m0 = m0;
    bus.q_s1 = s1;
    bus.q_s0 = s0;
  endtask

  task automatic check_strobes(input string tag, input logic [3:0] ce, input logic [3:0] ld,
                               input logic tick, input logic roll);
    check_eq({tag, ".ce"},   8'(bus.ce),       8'(ce));
    check_eq({tag, ".ld"},   8'(bus.ld),       8'(ld));
    check_eq({tag, ".tick"}, 8'(bus.tick),     8'(tick));
    check_eq({tag, ".roll"}, 8'(bus.rollover), 8'(roll));
  endtask

  // Advance one period of a 4-cycle tick: three idle steps, then the strobe step
  task automatic tick_period(input string tag, input logic [3:0] ce, input logic [3:0] ld,
                             input logic roll);
    for (int i = 1; i <= 3; i++) begin
      step();
      check_eq({tag, ".idle_tick"}, 8'(bus.tick), 8'd0);
    end
    step();
    check_strobes(tag, ce, ld, 1'b1, roll);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 0; bus.stop = 0; bus.set_en = 0; bus.inc_sec = 0;
    bus.inc_min = 0; bus.clr = 0; bus.fast = 0;
    set_q(0, 0, 0, 0);
    step();
    step();
    check_strobes("reset", 4'h0, 4'h0, 1'b0, 1'b0);
    check_eq("reset.mode", 8'(bus.mode), 8'd0);
    rst = 1'b0;
    step();

    // start sampled at this edge; strobes follow 4 cycles later
    bus.start = 1;
    step();
    bus.start = 0;
    check_eq("run.mode", 8'(bus.mode), 8'd1);
    tick_period("t1_0000", 4'b0001, 4'b0000, 1'b0);
    tick_period("t2_0000", 4'b0001, 4'b0000, 1'b0);

    set_q(0, 0, 0, 9);
    tick_period("t_0009", 4'b0011, 4'b0001, 1'b0);
    set_q(0, 0, 5, 9);
    tick_period("t_0059", 4'b0111, 4'b0011, 1'b0);
    set_q(5, 9, 5, 9);
    tick_period("t_5959", 4'b1111, 4'b1111, 1'b1);
    step();
    check_strobes("after_roll", 4'h0, 4'h0, 1'b0, 1'b0);

    // clr is ignored while running
    bus.clr = 1;
    step();
    bus.clr = 0;
    check_strobes("clr_run", 4'h0, 4'h0, 1'b0, 1'b0);
    check_eq("clr_run.mode", 8'(bus.mode), 8'd1);

    // stop wins over simultaneous start
    bus.stop = 1; bus.start = 1;
    step();
    bus.stop = 0; bus.start = 0;
    check_eq("stop_start.mode", 8'(bus.mode), 8'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("stopped.tick", 8'(bus.tick), 8'd0);
    end

    bus.clr = 1;
    step();
    bus.clr = 0;
    check_strobes("clr_stop", 4'hF, 4'hF, 1'b0, 1'b0);
    step();
    check_strobes("clr_stop_after", 4'h0, 4'h0, 1'b0, 1'b0);

    // SET mode: seconds do not carry into minutes
    bus.set_en = 1;
    set_q(0, 0, 5, 9);
    step();
    check_eq("set.mode", 8'(bus.mode), 8'd2);
    bus.inc_sec = 1;
    step();
    check_strobes("set_sec_0059", 4'b0011, 4'b0011, 1'b0, 1'b0);
    step();
    check_strobes("set_sec_held", 4'h0, 4'h0, 1'b0, 1'b0);
    bus.inc_sec = 0;
    step();
    // 09:00 plus one second and one minute: minutes go 09->10, so m1 is enabled too
    set_q(0, 9, 0, 0);
    bus.inc_sec = 1; bus.inc_min = 1;
    step();
    check_strobes("set_both_0900", 4'b1101, 4'b0100, 1'b0, 1'b0);
    bus.inc_sec = 0; bus.inc_min = 0;
    step();
    bus.inc_min = 1; bus.clr = 1;
    step();
    check_strobes("set_clr_wins", 4'hF, 4'hF, 1'b0, 1'b0);
    bus.inc_min = 0; bus.clr = 0;
    bus.set_en = 0;
    step();
    check_eq("set_exit.mode", 8'(bus.mode), 8'd0);
    set_q(0, 0, 0, 0);

    // fast divider: tick every 2 cycles
    bus.fast = 1; bus.start = 1;
    step();
    bus.start = 0;
    step();
    check_eq("fast.tick0", 8'(bus.tick), 8'd0);
    step();
    check_strobes("fast.t1", 4'b0001, 4'b0000, 1'b1, 1'b0);
    step();
    step();
    check_eq("fast.t2", 8'(bus.tick), 8'd1);
    bus.stop = 1;
    step();
    bus.stop = 0; bus.fast = 0;
    check_eq("fast_stop.mode", 8'(bus.mode), 8'd0);

    // rst during the advance cycle drops the pending strobe
    bus.start = 1;
    step();
    bus.start = 0;
    step(); step(); step();
    rst = 1;
    step();
    check_strobes("rst_mid", 4'h0, 4'h0, 1'b0, 1'b0);
    check_eq("rst_mid.mode", 8'(bus.mode), 8'd0);
    rst = 0;
    step();
    check_eq("rst_after.tick", 8'(bus.tick), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
